// File: rtl/rob_mw.sv
// rob_mw: multi-writeback, multi-retire reorder buffer.
// Circular in-order buffer between dispatch and the architectural register
// file. One dispatch per cycle, N_WB_PORTS writebacks per cycle, up to
// RETIRE_WIDTH in-order retirements per cycle, and N_RD_PORTS operand reads
// with same-cycle writeback forwarding. A retiring mispredicted entry empties
// the buffer and raises a registered one-cycle flush with the redirect PC.
module rob_mw #(
    parameter int N_ENTRIES    = 16,
    parameter int N_WB_PORTS   = 2,
    parameter int N_RD_PORTS   = 2,
    parameter int RETIRE_WIDTH = 2,
    parameter int ARF_ID_W     = 5,
    parameter int DATA_W       = 32,
    localparam int ID_W        = $clog2(N_ENTRIES)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             dispatch_valid,
    output logic                             dispatch_ready,
    output logic [ID_W-1:0]                  dispatch_rob_id,
    input  logic                             dispatch_dst_valid,
    input  logic [ARF_ID_W-1:0]              dispatch_dst_arf_id,
    input  logic [DATA_W-1:0]                dispatch_pc,
    input  logic [N_RD_PORTS*ID_W-1:0]       rd_rob_id,
    output logic [N_RD_PORTS-1:0]            rd_ready,
    output logic [N_RD_PORTS*DATA_W-1:0]     rd_data,
    input  logic [N_WB_PORTS-1:0]            wb_valid,
    input  logic [N_WB_PORTS*ID_W-1:0]       wb_rob_id,
    input  logic [N_WB_PORTS*DATA_W-1:0]     wb_data,
    input  logic [N_WB_PORTS-1:0]            wb_mispredict,
    input  logic [N_WB_PORTS*DATA_W-1:0]     wb_redirect_pc,
    output logic [RETIRE_WIDTH-1:0]          retire_valid,
    output logic [RETIRE_WIDTH-1:0]          retire_wen,
    output logic [RETIRE_WIDTH*ID_W-1:0]     retire_rob_id,
    output logic [RETIRE_WIDTH*ARF_ID_W-1:0] retire_arf_id,
    output logic [RETIRE_WIDTH*DATA_W-1:0]   retire_data,
    output logic                             flush_valid,
    output logic [DATA_W-1:0]                flush_pc
);

    localparam int CNT_W = ID_W + 1;

    // Pointers and occupancy
    logic [ID_W-1:0]      head_reg;
    logic [ID_W-1:0]      tail_reg;
    logic [CNT_W-1:0]     count_reg;

    // Per-entry status flags (reset)
    logic [N_ENTRIES-1:0] occupied_reg;
    logic [N_ENTRIES-1:0] ready_reg;
    logic [N_ENTRIES-1:0] mispredict_reg;

    // Per-entry payload (no reset needed; guarded by the flags above)
    logic                 dst_valid_mem [N_ENTRIES];
    logic [ARF_ID_W-1:0]  arf_id_mem    [N_ENTRIES];
    logic [DATA_W-1:0]    pc_mem        [N_ENTRIES];
    logic [DATA_W-1:0]    data_mem      [N_ENTRIES];
    logic [DATA_W-1:0]    redirect_mem  [N_ENTRIES];

    logic                 flush_valid_reg;
    logic [DATA_W-1:0]    flush_pc_reg;

    // Retire decode results
    logic [RETIRE_WIDTH-1:0] lane_valid;
    logic [CNT_W-1:0]        n_retired;
    logic                    mp_retire;
    logic [DATA_W-1:0]       mp_redirect_pc;

    logic                    dispatch_fire;
    logic [N_WB_PORTS-1:0]   wb_accept;

    // Dispatch handshake: blocked while a mispredicted entry retires so the
    // flush never has to reconcile with a new allocation.
    assign dispatch_ready  = (count_reg != CNT_W'(N_ENTRIES)) & ~mp_retire;
    assign dispatch_rob_id = tail_reg;
    assign dispatch_fire   = dispatch_valid & dispatch_ready;

    assign flush_valid = flush_valid_reg;
    assign flush_pc    = flush_pc_reg;

    // A writeback lands only on a live entry, and never in the flush cycle.
    genvar gi;
    generate
        for (gi = 0; gi < N_WB_PORTS; gi++) begin : g_wb_accept
            assign wb_accept[gi] = wb_valid[gi]
                                 & occupied_reg[wb_rob_id[gi*ID_W +: ID_W]]
                                 & ~flush_valid_reg;
        end
    endgenerate

    // Retire selection: a ready prefix of the buffer starting at head, cut
    // short after the first mispredicted entry.
    always_comb begin
        logic [ID_W-1:0] lane_id;
        logic            chain_ok;
        lane_valid     = '0;
        n_retired      = '0;
        mp_retire      = 1'b0;
        mp_redirect_pc = '0;
        chain_ok       = 1'b1;
        lane_id        = head_reg;
        for (int k = 0; k < RETIRE_WIDTH; k++) begin
            lane_id = head_reg + ID_W'(k);
            if (chain_ok && !mp_retire && (count_reg > CNT_W'(k))
                    && occupied_reg[lane_id] && ready_reg[lane_id]) begin
                lane_valid[k] = 1'b1;
                n_retired     = n_retired + CNT_W'(1);
                if (mispredict_reg[lane_id]) begin
                    mp_retire      = 1'b1;
                    mp_redirect_pc = redirect_mem[lane_id];
                end
            end else begin
                chain_ok = 1'b0;
            end
        end
    end

    // Retire lane outputs: lane k always reports entry head+k.
    generate
        for (gi = 0; gi < RETIRE_WIDTH; gi++) begin : g_retire
            logic [ID_W-1:0] lane_rid;
            assign lane_rid = head_reg + ID_W'(gi);
            assign retire_valid[gi] = lane_valid[gi];
            assign retire_wen[gi]   = lane_valid[gi] & dst_valid_mem[lane_rid];
            assign retire_rob_id[gi*ID_W +: ID_W]         = lane_rid;
            assign retire_arf_id[gi*ARF_ID_W +: ARF_ID_W] = arf_id_mem[lane_rid];
            assign retire_data[gi*DATA_W +: DATA_W]       = data_mem[lane_rid];
        end
    endgenerate

    // Operand reads: a same-cycle writeback (highest port) beats stored state.
    generate
        for (gi = 0; gi < N_RD_PORTS; gi++) begin : g_read
            logic [ID_W-1:0]   rid;
            logic              rdy;
            logic [DATA_W-1:0] val;
            assign rid = rd_rob_id[gi*ID_W +: ID_W];
            always_comb begin
                rdy = occupied_reg[rid] & ready_reg[rid];
                val = data_mem[rid];
                for (int p = 0; p < N_WB_PORTS; p++) begin
                    if (wb_valid[p] && (wb_rob_id[p*ID_W +: ID_W] == rid)) begin
                        rdy = 1'b1;
                        val = wb_data[p*DATA_W +: DATA_W];
                    end
                end
            end
            assign rd_ready[gi]                = rdy;
            assign rd_data[gi*DATA_W +: DATA_W] = val;
        end
    endgenerate

    // Control state: writeback flags, retire release, allocation, flush.
    // Statement order matters: a later non-blocking write wins, so retire
    // release precedes allocation (full-buffer reuse of head), and the flush
    // clear comes last.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_reg        <= '0;
            tail_reg        <= '0;
            count_reg       <= '0;
            occupied_reg    <= '0;
            ready_reg       <= '0;
            mispredict_reg  <= '0;
            flush_valid_reg <= 1'b0;
            flush_pc_reg    <= '0;
        end else begin
            flush_valid_reg <= mp_retire;
            if (mp_retire) begin
                flush_pc_reg <= mp_redirect_pc;
            end
            for (int p = 0; p < N_WB_PORTS; p++) begin
                if (wb_accept[p]) begin
                    ready_reg[wb_rob_id[p*ID_W +: ID_W]]      <= 1'b1;
                    mispredict_reg[wb_rob_id[p*ID_W +: ID_W]] <= wb_mispredict[p];
                end
            end
            for (int k = 0; k < RETIRE_WIDTH; k++) begin
                if (lane_valid[k]) begin
                    occupied_reg[head_reg + ID_W'(k)] <= 1'b0;
                end
            end
            if (mp_retire) begin
                occupied_reg <= '0;
                head_reg     <= head_reg + n_retired[ID_W-1:0];
                tail_reg     <= head_reg + n_retired[ID_W-1:0];
                count_reg    <= '0;
            end else begin
                if (dispatch_fire) begin
                    occupied_reg[tail_reg]   <= 1'b1;
                    ready_reg[tail_reg]      <= 1'b0;
                    mispredict_reg[tail_reg] <= 1'b0;
                    tail_reg                 <= tail_reg + ID_W'(1);
                end
                head_reg  <= head_reg + n_retired[ID_W-1:0];
                count_reg <= count_reg + CNT_W'(dispatch_fire) - n_retired;
            end
        end
    end

    // Payload storage: results and redirect targets from writeback, static
    // instruction fields from dispatch.
    always_ff @(posedge clk) begin
        for (int p = 0; p < N_WB_PORTS; p++) begin
            if (!rst && wb_accept[p]) begin
                data_mem[wb_rob_id[p*ID_W +: ID_W]]     <= wb_data[p*DATA_W +: DATA_W];
                redirect_mem[wb_rob_id[p*ID_W +: ID_W]] <= wb_redirect_pc[p*DATA_W +: DATA_W];
            end
        end
        if (!rst && dispatch_fire) begin
            dst_valid_mem[tail_reg] <= dispatch_dst_valid;
            arf_id_mem[tail_reg]    <= dispatch_dst_arf_id;
            pc_mem[tail_reg]        <= dispatch_pc;
        end
    end

endmodule

// File: tb/tb_rob_mw.sv
// tb_rob_mw: randomized bench for rob_mw against a queue-based reference
// model of the buffer (ordered list of live ids plus per-id records).
module tb_rob_mw;

    localparam int N  = 16;
    localparam int NW = 2;
    localparam int NR = 2;
    localparam int RW = 2;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int IW = 4;

    logic               clk;
    logic               rst;
    logic               dispatch_valid;
    logic               dispatch_ready;
    logic [IW-1:0]      dispatch_rob_id;
    logic               dispatch_dst_valid;
    logic [AW-1:0]      dispatch_dst_arf_id;
    logic [DW-1:0]      dispatch_pc;
    logic [NR*IW-1:0]   rd_rob_id;
    logic [NR-1:0]      rd_ready;
    logic [NR*DW-1:0]   rd_data;
    logic [NW-1:0]      wb_valid;
    logic [NW*IW-1:0]   wb_rob_id;
    logic [NW*DW-1:0]   wb_data;
    logic [NW-1:0]      wb_mispredict;
    logic [NW*DW-1:0]   wb_redirect_pc;
    logic [RW-1:0]      retire_valid;
    logic [RW-1:0]      retire_wen;
    logic [RW*IW-1:0]   retire_rob_id;
    logic [RW*AW-1:0]   retire_arf_id;
    logic [RW*DW-1:0]   retire_data;
    logic               flush_valid;
    logic [DW-1:0]      flush_pc;

    rob_mw #(
        .N_ENTRIES(N), .N_WB_PORTS(NW), .N_RD_PORTS(NR),
        .RETIRE_WIDTH(RW), .ARF_ID_W(AW), .DATA_W(DW)
    ) dut (
        .clk(clk), .rst(rst),
        .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
        .dispatch_rob_id(dispatch_rob_id), .dispatch_dst_valid(dispatch_dst_valid),
        .dispatch_dst_arf_id(dispatch_dst_arf_id), .dispatch_pc(dispatch_pc),
        .rd_rob_id(rd_rob_id), .rd_ready(rd_ready), .rd_data(rd_data),
        .wb_valid(wb_valid), .wb_rob_id(wb_rob_id), .wb_data(wb_data),
        .wb_mispredict(wb_mispredict), .wb_redirect_pc(wb_redirect_pc),
        .retire_valid(retire_valid), .retire_wen(retire_wen),
        .retire_rob_id(retire_rob_id), .retire_arf_id(retire_arf_id),
        .retire_data(retire_data), .flush_valid(flush_valid), .flush_pc(flush_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model: live ids in program order, plus per-id records.
    int            m_q[$];
    bit            m_rdy [N];
    bit            m_mp  [N];
    bit            m_dst [N];
    logic [AW-1:0] m_arf [N];
    logic [DW-1:0] m_data[N];
    logic [DW-1:0] m_rpc [N];
    int            m_head;
    int            m_tail;
    bit            m_fv;
    logic [DW-1:0] m_fpc;
    bit            m_known = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL cyc=%0d %s got=%0h exp=%0h", cyc, tag, got, exp);
        end
    endtask

    function automatic bit in_q(input int id);
        foreach (m_q[i]) if (m_q[i] == id) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_head = 0;
        m_tail = 0;
        m_fv   = 1'b0;
        m_fpc  = '0;
        for (int i = 0; i < N; i++) begin
            m_rdy[i] = 1'b0;
            m_mp[i]  = 1'b0;
        end
        m_known = 1'b1;
    endtask

    // One clock cycle: drive random inputs at the falling edge, compare the
    // DUT against the model mid-cycle, then advance the model at the rising edge.
    task automatic run_cycle(input bit do_rst, input int p_disp, input int p_wb, input int p_mp);
        int            nret;
        bit            mp;
        logic [DW-1:0] fpc;
        bit            dready;
        logic [RW-1:0] ev;
        logic [RW-1:0] ew;
        int            id;
        int            wid;
        bit            rdy_e;
        logic [DW-1:0] d_e;

        @(negedge clk);
        cyc++;
        rst                 = do_rst;
        dispatch_valid      = ($urandom_range(99) < p_disp);
        dispatch_dst_valid  = ($urandom_range(9) < 8);
        dispatch_dst_arf_id = AW'($urandom);
        dispatch_pc         = $urandom;
        for (int p = 0; p < NW; p++) begin
            wb_valid[p] = ($urandom_range(99) < p_wb);
            if (m_q.size() > 0 && $urandom_range(3) != 0)
                wid = m_q[$urandom_range(m_q.size() - 1)];
            else
                wid = $urandom_range(N - 1);
            wb_rob_id[p*IW +: IW]      = IW'(wid);
            wb_data[p*DW +: DW]        = $urandom;
            wb_mispredict[p]           = ($urandom_range(99) < p_mp);
            wb_redirect_pc[p*DW +: DW] = $urandom & 32'hFFFF_FFFC;
        end
        for (int r = 0; r < NR; r++) begin
            if ($urandom_range(1) == 1) begin
                wid = $urandom_range(NW - 1);
                rd_rob_id[r*IW +: IW] = wb_rob_id[wid*IW +: IW];
            end else begin
                rd_rob_id[r*IW +: IW] = IW'($urandom_range(N - 1));
            end
        end
        #1;

        // Expected retirement: ready prefix from the oldest, ending at the
        // first mispredicted entry.
        nret = 0; mp = 1'b0; fpc = '0; ev = '0; ew = '0;
        for (int k = 0; k < RW; k++) begin
            if (mp || k >= m_q.size()) break;
            id = m_q[k];
            if (!m_rdy[id]) break;
            ev[k] = 1'b1;
            ew[k] = m_dst[id];
            nret++;
            if (m_mp[id]) begin
                mp  = 1'b1;
                fpc = m_rpc[id];
            end
        end
        dready = (m_q.size() != N) && !mp;

        if (m_known) begin
            check_eq("dispatch_ready", dispatch_ready, dready);
            check_eq("dispatch_rob_id", dispatch_rob_id, m_tail);
            check_eq("retire_valid", retire_valid, ev);
            check_eq("retire_wen", retire_wen, ew);
            for (int k = 0; k < RW; k++) begin
                check_eq($sformatf("retire_rob_id%0d", k), retire_rob_id[k*IW +: IW], (m_head + k) % N);
                if (ev[k]) begin
                    id = m_q[k];
                    check_eq($sformatf("retire_arf_id%0d", k), retire_arf_id[k*AW +: AW], m_arf[id]);
                    check_eq($sformatf("retire_data%0d", k), retire_data[k*DW +: DW], m_data[id]);
                end
            end
            for (int r = 0; r < NR; r++) begin
                id    = rd_rob_id[r*IW +: IW];
                rdy_e = in_q(id) && m_rdy[id];
                d_e   = m_data[id];
                for (int p = 0; p < NW; p++) begin
                    if (wb_valid[p] && wb_rob_id[p*IW +: IW] == IW'(id)) begin
                        rdy_e = 1'b1;
                        d_e   = wb_data[p*DW +: DW];
                    end
                end
                check_eq($sformatf("rd_ready%0d", r), rd_ready[r], rdy_e);
                if (rdy_e) check_eq($sformatf("rd_data%0d", r), rd_data[r*DW +: DW], d_e);
            end
            check_eq("flush_valid", flush_valid, m_fv);
            check_eq("flush_pc", flush_pc, m_fpc);

            if (!do_rst) begin
                if (dispatch_valid && dready)
                    $display("cyc=%0d dispatch id=%0d dst=%0b arf=%0d", cyc, dispatch_rob_id, dispatch_dst_valid, dispatch_dst_arf_id);
                for (int k = 0; k < RW; k++)
                    if (retire_valid[k])
                        $display("cyc=%0d retire lane=%0d id=%0d wen=%0b data=%08h", cyc, k, retire_rob_id[k*IW +: IW], retire_wen[k], retire_data[k*DW +: DW]);
                if (flush_valid)
                    $display("cyc=%0d flush pc=%08h", cyc, flush_pc);
            end else begin
                $display("cyc=%0d reset", cyc);
            end
        end

        @(posedge clk);
        if (do_rst) begin
            model_reset();
        end else if (m_known) begin
            for (int p = 0; p < NW; p++) begin
                id = wb_rob_id[p*IW +: IW];
                if (wb_valid[p] && in_q(id) && !m_fv) begin
                    m_rdy[id]  = 1'b1;
                    m_data[id] = wb_data[p*DW +: DW];
                    m_mp[id]   = wb_mispredict[p];
                    m_rpc[id]  = wb_redirect_pc[p*DW +: DW];
                end
            end
            repeat (nret) void'(m_q.pop_front());
            m_head = (m_head + nret) % N;
            if (mp) begin
                m_tail = m_head;
                m_q.delete();
                m_fv  = 1'b1;
                m_fpc = fpc;
            end else begin
                m_fv = 1'b0;
                if (dispatch_valid && dready) begin
                    m_q.push_back(m_tail);
                    m_dst[m_tail] = dispatch_dst_valid;
                    m_arf[m_tail] = dispatch_dst_arf_id;
                    m_rdy[m_tail] = 1'b0;
                    m_mp[m_tail]  = 1'b0;
                    m_tail = (m_tail + 1) % N;
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        dispatch_valid = 1'b0; dispatch_dst_valid = 1'b0;
        dispatch_dst_arf_id = '0; dispatch_pc = '0;
        rd_rob_id = '0; wb_valid = '0; wb_rob_id = '0; wb_data = '0;
        wb_mispredict = '0; wb_redirect_pc = '0;

        // Reset, then idle reset-state outputs
        run_cycle(1'b1, 0, 0, 0);
        run_cycle(1'b1, 0, 0, 0);
        run_cycle(1'b0, 0, 0, 0);
        // Fill with no writebacks: ids 0..15 then not ready
        repeat (20) run_cycle(1'b0, 100, 0, 0);
        // Drain without mispredicts: multi-lane retire
        repeat (30) run_cycle(1'b0, 0, 80, 0);
        // Near-full streaming with occasional mispredicts
        repeat (500) run_cycle(1'b0, 90, 40, 2);
        // Mixed traffic with frequent mispredicts and periodic mid-stream reset
        for (int c = 0; c < 1500; c++) begin
            run_cycle((c % 500) == 250, 60, 50, 5);
        end
        // Heavy writeback, rare mispredict, to exercise wrap-around retires
        repeat (500) run_cycle(1'b0, 70, 80, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
